// File: rtl/addsub_issue_ctrl_if.sv
// Signals around the add/sub issue controller: request stream, result stream and unit port.
// master is the controller's view; slave is the dispatcher/consumer/unit view.
interface addsub_issue_ctrl_if #(
   parameter int PREC_LEN = 64,
   parameter int TAG_LEN  = 4
);
   logic                in_valid;
   logic                in_ready;
   logic [PREC_LEN-1:0] in_a;
   logic [PREC_LEN-1:0] in_b;
   logic                in_sub;
   logic [TAG_LEN-1:0]  in_tag;

   logic                out_valid;
   logic                out_ready;
   logic [PREC_LEN-1:0] out_result;
   logic [TAG_LEN-1:0]  out_tag;
   logic                out_timeout;

   logic                fu_enable;
   logic [PREC_LEN-1:0] fu_a;
   logic [PREC_LEN-1:0] fu_b;
   logic                fu_add_n;
   logic                fu_valid;
   logic [PREC_LEN-1:0] fu_result;

   modport master (
      input  in_valid, in_a, in_b, in_sub, in_tag, out_ready, fu_valid, fu_result,
      output in_ready, out_valid, out_result, out_tag, out_timeout,
             fu_enable, fu_a, fu_b, fu_add_n
   );

   modport slave (
      output in_valid, in_a, in_b, in_sub, in_tag, out_ready, fu_valid, fu_result,
      input  in_ready, out_valid, out_result, out_tag, out_timeout,
             fu_enable, fu_a, fu_b, fu_add_n
   );
endinterface

// File: rtl/addsub_issue_ctrl.sv
// Issue controller for the 2-cycle FP add/sub unit: one operation in flight,
// operands held stable, result (or timeout qNaN) returned on a valid/ready stream.
module addsub_issue_ctrl #(
   parameter int PREC_LEN = 64,
   parameter int TAG_LEN  = 4,
   parameter int TIMEOUT  = 8,
   parameter int CNT_LEN  = 16
) (
   input  logic                clk,
   input  logic                rst,
   addsub_issue_ctrl_if.master bus,
   output logic                busy,
   output logic [CNT_LEN-1:0]  done_cnt
);
   localparam int EXP_LEN = (PREC_LEN == 64) ? 11 :
                            (PREC_LEN == 32) ? 8  :
                            (PREC_LEN == 16) ? 5  : 15;
   localparam logic [PREC_LEN-1:0] ALL_ONES = '1;
   // Exponent all ones plus fraction MSB, sign clear.
   localparam logic [PREC_LEN-1:0] QNAN =
      (ALL_ONES >> (PREC_LEN - EXP_LEN - 1)) << (PREC_LEN - EXP_LEN - 2);
   localparam int TO_W = $clog2(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t              state_q;
   logic [TO_W-1:0]     to_cnt_q;
   logic [TO_W-1:0]     to_cnt_d;
   logic [PREC_LEN-1:0] fu_a_q;
   logic [PREC_LEN-1:0] fu_b_q;
   logic                fu_add_n_q;
   logic                fu_enable_q;
   logic [TAG_LEN-1:0]  tag_q;
   logic                out_valid_q;
   logic [PREC_LEN-1:0] out_result_q;
   logic [TAG_LEN-1:0]  out_tag_q;
   logic                out_timeout_q;
   logic [CNT_LEN-1:0]  done_cnt_q;
   logic                in_ready_d;
   logic                accept_d;

   // In DONE the slot frees up the same cycle the consumer takes the result.
   assign in_ready_d = ~rst & ((state_q == S_IDLE) |
                               ((state_q == S_DONE) & bus.out_ready));
   assign accept_d   = in_ready_d & bus.in_valid;
   assign to_cnt_d   = to_cnt_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         to_cnt_q      <= '0;
         fu_a_q        <= '0;
         fu_b_q        <= '0;
         fu_add_n_q    <= 1'b0;
         fu_enable_q   <= 1'b0;
         tag_q         <= '0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_tag_q     <= '0;
         out_timeout_q <= 1'b0;
         done_cnt_q    <= '0;
      end else begin
         fu_enable_q <= 1'b0;
         if (accept_d) begin
            fu_a_q     <= bus.in_a;
            fu_b_q     <= bus.in_b;
            fu_add_n_q <= bus.in_sub;
            tag_q      <= bus.in_tag;
         end
         case (state_q)
            S_IDLE: begin
               if (accept_d) begin
                  fu_enable_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               to_cnt_q <= '0;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               to_cnt_q <= to_cnt_d;
               if (bus.fu_valid) begin
                  out_result_q  <= bus.fu_result;
                  out_timeout_q <= 1'b0;
                  out_tag_q     <= tag_q;
                  out_valid_q   <= 1'b1;
                  state_q       <= S_DONE;
               end else if (to_cnt_q == TO_LAST) begin
                  out_result_q  <= QNAN;
                  out_timeout_q <= 1'b1;
                  out_tag_q     <= tag_q;
                  out_valid_q   <= 1'b1;
                  state_q       <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  done_cnt_q  <= done_cnt_q + 1'b1;
                  out_valid_q <= 1'b0;
                  if (accept_d) begin
                     fu_enable_q <= 1'b1;
                     state_q     <= S_ISSUE;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_d;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.out_timeout = out_timeout_q;
   assign bus.fu_enable   = fu_enable_q;
   assign bus.fu_a        = fu_a_q;
   assign bus.fu_b        = fu_b_q;
   assign bus.fu_add_n    = fu_add_n_q;
   assign busy            = (state_q != S_IDLE);
   assign done_cnt        = done_cnt_q;
endmodule
